// File: rtl/uart_rx_fifo_if.sv
// Bundles the receiver-side frame strobe and the consumer valid/ready port.
// Latency: none (wiring only).
// Backpressure: outReady from the consumer; the receiver side cannot be stalled.
//
// Signals:
//   rxDone/rxErr/rxOut  frame strobe, error flag and byte from the UART receiver
//   outValid/outData    head-of-FIFO byte towards the consumer
//   outReady            consumer accepts the head byte
//   count/full          occupancy status
//   overrun/errCount    sticky drop flag and saturating framing-error count
//   clearFlags          clears overrun and errCount
// Modports: master drives frames and consumes bytes; slave is the FIFO.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16,
    parameter int ERR_W = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             rxDone;
    logic             rxErr;
    logic [7:0]       rxOut;
    logic             outValid;
    logic [7:0]       outData;
    logic             outReady;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             overrun;
    logic [ERR_W-1:0] errCount;
    logic             clearFlags;

    modport master (
        output rxDone, rxErr, rxOut, outReady, clearFlags,
        input  outValid, outData, count, full, overrun, errCount
    );

    modport slave (
        input  rxDone, rxErr, rxOut, outReady, clearFlags,
        output outValid, outData, count, full, overrun, errCount
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Captures each completed UART frame into a first-word-fall-through FIFO.
// Latency: a byte whose rxDone edge is sampled at edge k is on outData from cycle k+1.
// Backpressure: consumer stalls with outReady=0; good frames arriving when full are dropped and flag overrun.
//
// Ports:
//   clk    system clock, all state on posedge
//   reset  synchronous active-high reset
//   bus    uart_rx_fifo_if.slave (frame input, valid/ready output, status)
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int ERR_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_fifo_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              rx_done_q;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              overrun_q;
    logic [ERR_W-1:0]  err_count_q;
    logic [7:0]        mem [DEPTH];

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic done_edge;
    logic good_frame;
    logic bad_frame;
    logic not_empty;
    logic is_full;
    logic pop;
    logic push;
    logic drop;
    logic err_sat;

    always_comb begin
        done_edge  = bus.rxDone & ~rx_done_q;
        good_frame = done_edge & ~bus.rxErr;
        bad_frame  = done_edge &  bus.rxErr;
        not_empty  = (count_q != '0);
        is_full    = (count_q == CNT_W'(DEPTH));
        pop        = not_empty & bus.outReady;
        // A pop in the same cycle frees the slot the push needs, so a full
        // FIFO can still accept a byte while it is being read.
        push       = good_frame & (~is_full | pop);
        drop       = good_frame & is_full & ~pop;
        err_sat    = (err_count_q == {ERR_W{1'b1}});
    end

    // ------------------------------------------------------------------
    // Edge detector, pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // Load the live level so a strobe held across reset is not a frame.
            rx_done_q <= bus.rxDone;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count_q   <= '0;
        end else begin
            rx_done_q <= bus.rxDone;
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage: contents are meaningless while empty, so no reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= bus.rxOut;
        end
    end

    // ------------------------------------------------------------------
    // Sticky status. A new event in the same cycle as clearFlags wins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (bus.clearFlags) begin
            overrun_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_q <= '0;
        end else if (bad_frame) begin
            if (bus.clearFlags) begin
                err_count_q <= ERR_W'(1);
            end else if (!err_sat) begin
                err_count_q <= err_count_q + ERR_W'(1);
            end
        end else if (bus.clearFlags) begin
            err_count_q <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: registered state only, nothing combinational from outReady.
    // ------------------------------------------------------------------
    assign bus.outValid = not_empty;
    assign bus.outData  = mem[rd_ptr];
    assign bus.count    = count_q;
    assign bus.full     = is_full;
    assign bus.overrun  = overrun_q;
    assign bus.errCount = err_count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int ERR_W = 8;

    logic clk;
    logic reset;

    uart_rx_fifo_if #(.DEPTH(DEPTH), .ERR_W(ERR_W)) bus();

    uart_rx_fifo #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: FIFO contents as a queue, counters as plain ints.
    // exp_q is the scoreboard of bytes the consumer must see, in order.
    // ------------------------------------------------------------------
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    bit         m_prev;
    int         m_err;
    bit         m_ovr;
    bit         m_edge;
    bit         m_pop;
    bit         m_drop;

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            exp_q.delete();
            m_prev = bus.rxDone;
            m_err  = 0;
            m_ovr  = 0;
        end else begin
            m_edge = bus.rxDone && !m_prev;
            m_prev = bus.rxDone;
            m_pop  = (m_q.size() > 0) && bus.outReady;
            m_drop = 0;
            if (m_pop) void'(m_q.pop_front());
            if (m_edge && !bus.rxErr) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(bus.rxOut);
                    exp_q.push_back(bus.rxOut);
                end else begin
                    m_drop = 1;
                end
            end
            if (m_edge && bus.rxErr)
                m_err = bus.clearFlags ? 1 : ((m_err >= 255) ? 255 : m_err + 1);
            else if (bus.clearFlags)
                m_err = 0;
            if (m_drop)
                m_ovr = 1;
            else if (bus.clearFlags)
                m_ovr = 0;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: status every cycle, data whenever a transfer happens.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count",    32'(bus.count),    32'(m_q.size()));
            chk("full",     32'(bus.full),     32'(m_q.size() == DEPTH));
            chk("outValid", 32'(bus.outValid), 32'(m_q.size() != 0));
            chk("overrun",  32'(bus.overrun),  32'(m_ovr));
            chk("errCount", 32'(bus.errCount), 32'(m_err));
            if (bus.outValid && bus.outReady) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 32'(bus.outData), 32'hFFFF_FFFF);
                end else begin
                    chk("outData", 32'(bus.outData), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] b, input logic err);
        bus.rxOut  = b;
        bus.rxErr  = err;
        bus.rxDone = 1'b1;
        tick();
        bus.rxDone = 1'b0;
        bus.rxErr  = 1'b0;
        tick();
    endtask

    task automatic drain(input int cycles);
        bus.outReady = 1'b1;
        repeat (cycles) tick();
        bus.outReady = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset          = 1'b1;
        bus.rxDone     = 1'b0;
        bus.rxErr      = 1'b0;
        bus.rxOut      = 8'h00;
        bus.outReady   = 1'b0;
        bus.clearFlags = 1'b0;
        tick();
        mon_en = 1;
        do_reset();
        chk("reset_count", 32'(bus.count), 0);
        chk("reset_valid", 32'(bus.outValid), 0);

        // 1: single frame, then one-cycle pop
        frame(8'hD6, 1'b0);
        chk("t1_count", 32'(bus.count), 1);
        chk("t1_data",  32'(bus.outData), 32'h D6);
        bus.outReady = 1'b1;
        tick();
        bus.outReady = 1'b0;
        tick();
        chk("t1_empty", 32'(bus.outValid), 0);

        // 2: long level is one frame; level held across reset is no frame
        bus.rxOut  = 8'h5A;
        bus.rxDone = 1'b1;
        repeat (20) tick();
        bus.rxDone = 1'b0;
        tick();
        chk("t2_one_entry", 32'(bus.count), 1);
        drain(2);
        bus.rxDone = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        bus.rxDone = 1'b0;
        tick();
        chk("t2_held_reset", 32'(bus.count), 0);

        // 3: error frame discarded, error counter saturates
        frame(8'h01, 1'b0);
        frame(8'h02, 1'b1);
        frame(8'h03, 1'b0);
        chk("t3_count", 32'(bus.count), 2);
        chk("t3_err",   32'(bus.errCount), 1);
        drain(3);
        for (int i = 0; i < 260; i++) frame(8'(i), 1'b1);
        chk("t3_err_sat", 32'(bus.errCount), 32'hFF);

        // 4: overflow by one, in-order drain, clearFlags
        for (int i = 0; i <= DEPTH; i++) frame(8'(i), 1'b0);
        chk("t4_count",   32'(bus.count), DEPTH);
        chk("t4_full",    32'(bus.full), 1);
        chk("t4_overrun", 32'(bus.overrun), 1);
        drain(DEPTH + 2);
        bus.clearFlags = 1'b1;
        tick();
        bus.clearFlags = 1'b0;
        tick();
        chk("t4_clr_ovr", 32'(bus.overrun), 0);
        chk("t4_clr_err", 32'(bus.errCount), 0);

        // 5: push and pop together while full
        for (int i = 0; i < DEPTH; i++) frame(8'(8'h40 + i), 1'b0);
        bus.rxOut    = 8'hAA;
        bus.rxDone   = 1'b1;
        bus.outReady = 1'b1;
        tick();
        bus.rxDone   = 1'b0;
        bus.outReady = 1'b0;
        tick();
        chk("t5_count",   32'(bus.count), DEPTH);
        chk("t5_overrun", 32'(bus.overrun), 0);
        drain(DEPTH + 2);

        // 5b: randomized traffic; first half mostly stalls to hit full
        for (int i = 0; i < 800; i++) begin
            bus.rxDone     = 1'($urandom_range(0, 1));
            bus.rxErr      = ($urandom_range(0, 7) == 0);
            bus.rxOut      = 8'($urandom);
            bus.outReady   = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            bus.clearFlags = ($urandom_range(0, 31) == 0);
            tick();
        end
        bus.rxDone     = 1'b0;
        bus.rxErr      = 1'b0;
        bus.clearFlags = 1'b0;
        drain(DEPTH + 2);

        // 6: reset with stored bytes and toggling outReady
        for (int i = 0; i < 5; i++) frame(8'(8'h90 + i), 1'b0);
        bus.outReady = 1'b1;
        tick();
        bus.outReady = 1'b0;
        reset = 1'b1;
        tick();
        bus.outReady = 1'b1;
        reset = 1'b0;
        chk("t6_count",   32'(bus.count), 0);
        chk("t6_valid",   32'(bus.outValid), 0);
        chk("t6_overrun", 32'(bus.overrun), 0);
        bus.outReady = 1'b0;
        tick();
        frame(8'h77, 1'b0);
        chk("t6_first", 32'(bus.outData), 32'h77);
        drain(2);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        mon_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
